// File: rtl/divrem_sequencer_pkg.sv
// Shared constants and helpers for the RV32M divide/remainder sequencer.
package divrem_sequencer_pkg;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } divremState_t;

    localparam int unsigned DIVREM_DATA_WIDTH = 32;
    localparam int unsigned DIVREM_ITERS      = DIVREM_DATA_WIDTH;

    // Codes outside DIV/REM fall through to unsigned behaviour.
    function automatic logic isSignedOp(input logic [2:0] funct3);
        return (funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM);
    endfunction

    function automatic logic isRemOp(input logic [2:0] funct3);
        return (funct3 == FUNCT3_REM) || (funct3 == FUNCT3_REMU);
    endfunction

endpackage

// File: rtl/divrem_sequencer_if.sv
// EX-stage <-> divide sequencer handshake and operand/result bus.
interface divrem_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  iStart;
    logic [2:0]            iFunct3;
    logic [DATA_WIDTH-1:0] iRs1;
    logic [DATA_WIDTH-1:0] iRs2;
    logic                  iFlush;
    logic                  oStall;
    logic                  oBusy;
    logic                  oValid;
    logic [DATA_WIDTH-1:0] oResult;

    modport master (
        output iStart, iFunct3, iRs1, iRs2, iFlush,
        input  oStall, oBusy, oValid, oResult
    );

    modport slave (
        input  iStart, iFunct3, iRs1, iRs2, iFlush,
        output oStall, oBusy, oValid, oResult
    );
endinterface

// File: rtl/divrem_sequencer_step.sv
// One radix-2 restoring division step: shift {rem,quot}, trial subtract divisor.
module divrem_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] iRem,
    input  logic [DATA_WIDTH-1:0] iQuot,
    input  logic [DATA_WIDTH-1:0] iDivisor,
    output logic [DATA_WIDTH-1:0] oRem,
    output logic [DATA_WIDTH-1:0] oQuot
);
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;
    logic                fits;

    // Since rem < divisor on entry, the MSB of the (W+1)-bit difference is
    // exactly the borrow of the trial subtraction.
    always_comb begin
        shifted = {iRem, iQuot[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, iDivisor};
        fits    = ~diff[DATA_WIDTH];
        oRem    = fits ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
        oQuot   = {iQuot[DATA_WIDTH-2:0], fits};
    end
endmodule

// File: rtl/divrem_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer with precise pipeline stall.
// Optional: define DIVREM_EARLY_OUT_EN to skip iteration when |dividend| < |divisor|
// or divisor == 1.
module divrem_sequencer
    import divrem_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic               iCLK,
    input  logic               iRST,
    divrem_sequencer_if.slave  bus
);
    divremState_t          state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  opRem;
    logic                  negQuot;
    logic                  negRem;
    logic [DATA_WIDTH-1:0] divisorMag;
    logic [DATA_WIDTH-1:0] remReg;
    logic [DATA_WIDTH-1:0] quotReg;
    logic [DATA_WIDTH-1:0] stepRem;
    logic [DATA_WIDTH-1:0] stepQuot;

    logic                  startSigned;
    logic                  startRem;
    logic                  rs1Neg;
    logic                  rs2Neg;
    logic [DATA_WIDTH-1:0] rs1Mag;
    logic [DATA_WIDTH-1:0] rs2Mag;
    logic                  divByZero;
    logic                  overflow;

    divrem_step #(.DATA_WIDTH(DATA_WIDTH)) uStep (
        .iRem     (remReg),
        .iQuot    (quotReg),
        .iDivisor (divisorMag),
        .oRem     (stepRem),
        .oQuot    (stepQuot)
    );

    // Decode the incoming operation and operand magnitudes for the IDLE cycle.
    always_comb begin
        startSigned = isSignedOp(bus.iFunct3);
        startRem    = isRemOp(bus.iFunct3);
        rs1Neg      = startSigned & bus.iRs1[DATA_WIDTH-1];
        rs2Neg      = startSigned & bus.iRs2[DATA_WIDTH-1];
        rs1Mag      = rs1Neg ? (~bus.iRs1 + 1'b1) : bus.iRs1;
        rs2Mag      = rs2Neg ? (~bus.iRs2 + 1'b1) : bus.iRs2;
        divByZero   = (bus.iRs2 == '0);
        overflow    = startSigned
                      && (bus.iRs1 == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                      && (bus.iRs2 == '1);
    end

    assign bus.oStall = bus.iStart && (state != ST_DONE) && !iRST && !bus.iFlush;

    // Sequencer FSM with registered busy/valid/result.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            opRem       <= 1'b0;
            negQuot     <= 1'b0;
            negRem      <= 1'b0;
            divisorMag  <= '0;
            remReg      <= '0;
            quotReg     <= '0;
            bus.oBusy   <= 1'b0;
            bus.oValid  <= 1'b0;
            bus.oResult <= '0;
        end else if (bus.iFlush) begin
            state      <= ST_IDLE;
            bus.oBusy  <= 1'b0;
            bus.oValid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.oValid <= 1'b0;
                    bus.oBusy  <= 1'b0;
                    if (bus.iStart) begin
                        opRem      <= startRem;
                        negQuot    <= rs1Neg ^ rs2Neg;
                        negRem     <= rs1Neg;
                        divisorMag <= rs2Mag;
                        if (divByZero) begin
                            bus.oResult <= startRem ? bus.iRs1 : '1;
                            bus.oValid  <= 1'b1;
                            state       <= ST_DONE;
                        end else if (overflow) begin
                            bus.oResult <= startRem ? '0 : {1'b1, {(DATA_WIDTH-1){1'b0}}};
                            bus.oValid  <= 1'b1;
                            state       <= ST_DONE;
                        end
`ifdef DIVREM_EARLY_OUT_EN
                        else if (rs2Mag == DATA_WIDTH'(1)) begin
                            quotReg   <= rs1Mag;
                            remReg    <= '0;
                            bus.oBusy <= 1'b1;
                            state     <= ST_FIX;
                        end else if (rs1Mag < rs2Mag) begin
                            quotReg   <= '0;
                            remReg    <= rs1Mag;
                            bus.oBusy <= 1'b1;
                            state     <= ST_FIX;
                        end
`endif
                        else begin
                            quotReg   <= rs1Mag;
                            remReg    <= '0;
                            cnt       <= CNT_WIDTH'(DATA_WIDTH - 1);
                            bus.oBusy <= 1'b1;
                            state     <= ST_ITER;
                        end
                    end
                end
                ST_ITER: begin
                    remReg  <= stepRem;
                    quotReg <= stepQuot;
                    if (cnt == '0) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_FIX: begin
                    if (opRem) begin
                        bus.oResult <= negRem ? (~remReg + 1'b1) : remReg;
                    end else begin
                        bus.oResult <= negQuot ? (~quotReg + 1'b1) : quotReg;
                    end
                    bus.oBusy  <= 1'b0;
                    bus.oValid <= 1'b1;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    bus.oValid <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    bus.oBusy  <= 1'b0;
                    bus.oValid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_divrem_sequencer.sv
// Scoreboard bench for divrem_sequencer: expected results queued at start, popped on oValid.
module tb_divrem_sequencer;
    import divrem_sequencer_pkg::*;

    localparam int W = 32;

    logic iCLK = 1'b0;
    logic iRST;

    always #5 iCLK = ~iCLK;

    divrem_sequencer_if #(.DATA_WIDTH(W)) bus ();

    divrem_sequencer #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] expQ [$];

    task automatic checkVal(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] refResult(input logic [2:0] f3, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic sgn;
        logic rem;
        sgn = (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
        rem = (f3 == FUNCT3_REM) || (f3 == FUNCT3_REMU);
        if (b == 0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
        if (sgn) return rem ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
        return rem ? a % b : a / b;
    endfunction

    function automatic int refStalls(input logic [2:0] f3, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        logic sgn;
        logic [W-1:0] ma;
        logic [W-1:0] mb;
        sgn = (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        ma = (sgn && a[W-1]) ? -a : a;
        mb = (sgn && b[W-1]) ? -b : b;
`ifdef DIVREM_EARLY_OUT_EN
        if (mb == 1 || ma < mb) return 2;
`else
        if (ma == mb && ma == 0) return 0;
`endif
        return 34;
    endfunction

    // Drive one op (called just after a negedge), wait for oValid, check latency and result.
    task automatic runOp(input string tag, input logic [2:0] f3, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        int stalls;
        bit seen;
        logic [W-1:0] exp;
        bus.iStart  = 1'b1;
        bus.iFunct3 = f3;
        bus.iRs1    = a;
        bus.iRs2    = b;
        expQ.push_back(refResult(f3, a, b));
        stalls = 0;
        seen   = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (bus.oValid) begin
                seen = 1'b1;
                break;
            end
            if (bus.oStall) stalls++;
            @(negedge iCLK);
        end
        checkVal({tag, ":valid"}, W'(seen), W'(1));
        if (seen) begin
            checkVal({tag, ":stalls"}, W'(stalls), W'(refStalls(f3, a, b)));
            checkVal({tag, ":doneStall"}, W'(bus.oStall), W'(0));
            if (expQ.size() == 0) begin
                checkVal({tag, ":sbEmpty"}, W'(1), W'(0));
            end else begin
                exp = expQ.pop_front();
                checkVal({tag, ":result"}, bus.oResult, exp);
            end
        end else begin
            void'(expQ.pop_back());
        end
    endtask

    initial begin
        logic [2:0]   rf3;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int pulses;

        iRST        = 1'b1;
        bus.iStart  = 1'b1;
        bus.iFunct3 = FUNCT3_DIVU;
        bus.iRs1    = 32'd100;
        bus.iRs2    = 32'd7;
        bus.iFlush  = 1'b0;
        repeat (3) @(negedge iCLK);
        #1;
        checkVal("rst:stall", W'(bus.oStall), W'(0));
        checkVal("rst:busy", W'(bus.oBusy), W'(0));
        checkVal("rst:valid", W'(bus.oValid), W'(0));
        checkVal("rst:result", bus.oResult, W'(0));
        @(negedge iCLK);
        iRST       = 1'b0;
        bus.iStart = 1'b0;
        @(negedge iCLK);

        // Directed ops, issued back to back with no gap between DONE and the next IDLE.
        runOp("divu100_7", FUNCT3_DIVU, 32'd100, 32'd7);
        @(negedge iCLK); runOp("remu100_7", FUNCT3_REMU, 32'd100, 32'd7);
        @(negedge iCLK); runOp("div_m100_7", FUNCT3_DIV, 32'hFFFF_FF9C, 32'd7);
        @(negedge iCLK); runOp("rem_m100_7", FUNCT3_REM, 32'hFFFF_FF9C, 32'd7);
        @(negedge iCLK); runOp("div5_0", FUNCT3_DIV, 32'd5, 32'd0);
        @(negedge iCLK); runOp("rem5_0", FUNCT3_REM, 32'd5, 32'd0);
        @(negedge iCLK); runOp("div_ovf", FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        @(negedge iCLK); runOp("rem_ovf", FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        @(negedge iCLK); runOp("f3_000", 3'b000, 32'd100, 32'd7);
        @(negedge iCLK); runOp("b2b_20_4", FUNCT3_DIVU, 32'd20, 32'd4);
        @(negedge iCLK); runOp("b2b_21_4", FUNCT3_DIVU, 32'd21, 32'd4);
        @(negedge iCLK); runOp("divu3_10", FUNCT3_DIVU, 32'd3, 32'd10);
        @(negedge iCLK);
        bus.iStart = 1'b0;
        repeat (2) @(negedge iCLK);

        // Flush partway through iteration.
        bus.iStart  = 1'b1;
        bus.iFunct3 = FUNCT3_DIVU;
        bus.iRs1    = 32'hFFFF_FFFF;
        bus.iRs2    = 32'd3;
        repeat (11) @(negedge iCLK);
        #1;
        checkVal("flush:busyBefore", W'(bus.oBusy), W'(1));
        bus.iFlush = 1'b1;
        #1;
        checkVal("flush:stall", W'(bus.oStall), W'(0));
        @(negedge iCLK);
        bus.iFlush = 1'b0;
        #1;
        checkVal("flush:busy", W'(bus.oBusy), W'(0));
        checkVal("flush:valid", W'(bus.oValid), W'(0));
        runOp("postflush9_3", FUNCT3_DIVU, 32'd9, 32'd3);

        // Operand changes during iteration must be ignored.
        @(negedge iCLK);
        bus.iStart  = 1'b1;
        bus.iFunct3 = FUNCT3_DIVU;
        bus.iRs1    = 32'd1000;
        bus.iRs2    = 32'd9;
        expQ.push_back(32'd111);
        @(negedge iCLK);
        bus.iRs1 = 32'd5;
        bus.iRs2 = 32'd2;
        pulses = 0;
        for (int c = 0; c < 100 && pulses == 0; c++) begin
            #1;
            if (bus.oValid) pulses++;
            else @(negedge iCLK);
        end
        checkVal("hold:valid", W'(pulses), W'(1));
        if (pulses != 0) checkVal("hold:result", bus.oResult, expQ.pop_front());
        else void'(expQ.pop_front());

        // Random ops against the reference model.
        for (int n = 0; n < 10; n++) begin
            @(negedge iCLK);
            rf3 = {1'b1, 2'($urandom_range(0, 3))};
            ra  = $urandom;
            if ($urandom_range(0, 1) == 0) ra = W'($urandom_range(0, 200));
            case ($urandom_range(0, 3))
                0:       rb = W'($urandom_range(0, 3));
                1:       rb = W'($urandom_range(1, 50));
                2:       rb = -W'($urandom_range(1, 50));
                default: rb = $urandom;
            endcase
            runOp($sformatf("rnd%0d", n), rf3, ra, rb);
        end

        // Reset mid-operation clears the result register.
        @(negedge iCLK);
        runOp("prerst7_2", FUNCT3_DIVU, 32'd7, 32'd2);
        @(negedge iCLK);
        bus.iRs1 = 32'd1234;
        bus.iRs2 = 32'd5;
        repeat (6) @(negedge iCLK);
        iRST = 1'b1;
        #1;
        checkVal("midrst:stall", W'(bus.oStall), W'(0));
        @(negedge iCLK);
        #1;
        checkVal("midrst:result", bus.oResult, W'(0));
        checkVal("midrst:busy", W'(bus.oBusy), W'(0));
        bus.iStart = 1'b0;
        @(negedge iCLK);
        iRST = 1'b0;
        repeat (2) @(negedge iCLK);

        checkVal("sb:leftover", W'(expQ.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
